// File: rtl/branch_predictor_gshare_if.sv
// Interface bundling the fetch-side lookup, execute-side update and
// statistics signals of the gshare branch predictor.
//   master : pipeline side (drives lookup PC, update info, stall)
//   slave  : predictor side (drives prediction, history snapshot, stats)
// Lookup: rd_pc_i, rd_branch_i -> rd_hit_o, rd_target_o, rd_ghr_o
// Update: upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_pred_i,
//         upd_target_i, stall_i
// Stats : stat_branch_o, stat_miss_o
interface branch_predictor_gshare_if #(
    parameter int HIST_LEN = 4,
    parameter int STAT_BIT = 16
);
    logic [31:0]         rd_pc_i;
    logic                rd_branch_i;
    logic                rd_hit_o;
    logic [31:0]         rd_target_o;
    logic [HIST_LEN-1:0] rd_ghr_o;
    logic                upd_valid_i;
    logic [31:0]         upd_pc_i;
    logic [HIST_LEN-1:0] upd_ghr_i;
    logic                upd_taken_i;
    logic                upd_pred_i;
    logic [31:0]         upd_target_i;
    logic                stall_i;
    logic [STAT_BIT-1:0] stat_branch_o;
    logic [STAT_BIT-1:0] stat_miss_o;

    modport master (
        output rd_pc_i, rd_branch_i, upd_valid_i, upd_pc_i, upd_ghr_i,
               upd_taken_i, upd_pred_i, upd_target_i, stall_i,
        input  rd_hit_o, rd_target_o, rd_ghr_o, stat_branch_o, stat_miss_o
    );

    modport slave (
        input  rd_pc_i, rd_branch_i, upd_valid_i, upd_pc_i, upd_ghr_i,
               upd_taken_i, upd_pred_i, upd_target_i, stall_i,
        output rd_hit_o, rd_target_o, rd_ghr_o, stat_branch_o, stat_miss_o
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare branch direction predictor with a tagged, direct-mapped BTB and
// saturating performance counters. Lookup is combinational (IF stage);
// update is synchronous from EX resolution and is blocked by stall_i.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : branch_predictor_gshare_if.slave (lookup, update, stats)
module branch_predictor_gshare #(
    parameter int NUM_INDEX_BIT = 4,
    parameter int HIST_LEN      = 4,
    parameter int TAG_BIT       = 8,
    parameter int CTR_BIT       = 2,
    parameter int USE_GSHARE    = 1,
    parameter int STAT_BIT      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_predictor_gshare_if.slave bus
);
    localparam int ENTRIES = 1 << NUM_INDEX_BIT;
    localparam logic [CTR_BIT-1:0]  CTR_INIT = CTR_BIT'((1 << (CTR_BIT - 1)) - 1);
    localparam logic [CTR_BIT-1:0]  CTR_MAX  = '1;
    localparam logic [STAT_BIT-1:0] STAT_MAX = '1;

    // Reject illegal parameter combinations at elaboration time.
    generate
        if (HIST_LEN < 1 || HIST_LEN > NUM_INDEX_BIT) begin : g_bad_hist_len
            $fatal(1, "HIST_LEN must lie in 1..NUM_INDEX_BIT");
        end
        if (CTR_BIT < 2 || CTR_BIT > 4) begin : g_bad_ctr_bit
            $fatal(1, "CTR_BIT must lie in 2..4");
        end
        if (NUM_INDEX_BIT + TAG_BIT > 30) begin : g_bad_tag_bit
            $fatal(1, "index and tag fields must fit below PC bit 31");
        end
    endgenerate

    logic [CTR_BIT-1:0]  pht [ENTRIES];
    logic [ENTRIES-1:0]  btb_valid;
    logic [TAG_BIT-1:0]  btb_tag [ENTRIES];
    logic [31:0]         btb_target [ENTRIES];
    logic [HIST_LEN-1:0] ghr;
    logic [HIST_LEN-1:0] ghr_next;
    logic [STAT_BIT-1:0] stat_branch;
    logic [STAT_BIT-1:0] stat_miss;
    logic [CTR_BIT-1:0]  pht_next;

    logic [NUM_INDEX_BIT-1:0] rd_bidx, rd_pidx, upd_bidx, upd_pidx;
    logic [TAG_BIT-1:0]       rd_tag, upd_tag;
    logic                     upd_fire;
    logic                     unused_pc_bits;

    // Bit 0 is always zero for halfword-aligned PCs and bits above the tag
    // field do not take part in indexing or tagging.
    assign unused_pc_bits = ^{bus.rd_pc_i[0], bus.rd_pc_i[31:NUM_INDEX_BIT+TAG_BIT+1],
                              bus.upd_pc_i[0], bus.upd_pc_i[31:NUM_INDEX_BIT+TAG_BIT+1]};

    // The BTB is always indexed by PC alone; the PHT optionally folds in the
    // zero-extended history. EX uses the snapshot taken at fetch so both
    // sides address the same counter.
    assign rd_bidx  = bus.rd_pc_i[NUM_INDEX_BIT:1];
    assign rd_tag   = bus.rd_pc_i[NUM_INDEX_BIT+TAG_BIT:NUM_INDEX_BIT+1];
    assign rd_pidx  = (USE_GSHARE != 0) ? (rd_bidx ^ NUM_INDEX_BIT'(ghr)) : rd_bidx;
    assign upd_bidx = bus.upd_pc_i[NUM_INDEX_BIT:1];
    assign upd_tag  = bus.upd_pc_i[NUM_INDEX_BIT+TAG_BIT:NUM_INDEX_BIT+1];
    assign upd_pidx = (USE_GSHARE != 0) ? (upd_bidx ^ NUM_INDEX_BIT'(bus.upd_ghr_i)) : upd_bidx;
    assign upd_fire = bus.upd_valid_i & ~bus.stall_i;

    // Taken prediction needs a matching valid BTB entry and the counter MSB.
    assign bus.rd_hit_o      = bus.rd_branch_i & btb_valid[rd_bidx] &
                               (btb_tag[rd_bidx] == rd_tag) & pht[rd_pidx][CTR_BIT-1];
    assign bus.rd_target_o   = btb_target[rd_bidx];
    assign bus.rd_ghr_o      = ghr;
    assign bus.stat_branch_o = stat_branch;
    assign bus.stat_miss_o   = stat_miss;

    // Saturating up/down step of the addressed direction counter.
    always_comb begin
        pht_next = pht[upd_pidx];
        if (bus.upd_taken_i) begin
            if (pht[upd_pidx] != CTR_MAX) pht_next = pht[upd_pidx] + CTR_BIT'(1);
        end else begin
            if (pht[upd_pidx] != '0) pht_next = pht[upd_pidx] - CTR_BIT'(1);
        end
    end

    // A one-bit history simply holds the latest outcome.
    generate
        if (HIST_LEN == 1) begin : g_ghr_one
            assign ghr_next = bus.upd_taken_i;
        end else begin : g_ghr_shift
            assign ghr_next = {ghr[HIST_LEN-2:0], bus.upd_taken_i};
        end
    endgenerate

    // Architectural predictor state; a reset coinciding with an update wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_INIT;
            btb_valid   <= '0;
            ghr         <= '0;
            stat_branch <= '0;
            stat_miss   <= '0;
        end else if (upd_fire) begin
            pht[upd_pidx] <= pht_next;
            if (bus.upd_taken_i) btb_valid[upd_bidx] <= 1'b1;
            ghr <= ghr_next;
            if (stat_branch != STAT_MAX) stat_branch <= stat_branch + STAT_BIT'(1);
            if ((bus.upd_pred_i != bus.upd_taken_i) && (stat_miss != STAT_MAX))
                stat_miss <= stat_miss + STAT_BIT'(1);
        end
    end

    // Tag and target payload need no reset since the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (upd_fire && bus.upd_taken_i) begin
            btb_tag[upd_bidx]    <= upd_tag;
            btb_target[upd_bidx] <= bus.upd_target_i;
        end
    end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench: a bimodal instance (16-bit stats) and a gshare
// instance (4-bit stats) receive identical stimulus and are compared with
// an array-based reference model of the predictor rules.
module tb_branch_predictor_gshare;
    logic        clk;
    logic        rst_n;
    logic [31:0] rd_pc;
    logic        rd_branch;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_pred;
    logic [31:0] upd_target;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_pht_b [16];
    int          m_pht_g [16];
    bit          m_v [16];
    int          m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ghr;
    int          m_nbr;
    int          m_nmiss;

    branch_predictor_gshare_if #(.HIST_LEN(4), .STAT_BIT(16)) bus_b ();
    branch_predictor_gshare_if #(.HIST_LEN(4), .STAT_BIT(4))  bus_g ();

    branch_predictor_gshare #(.NUM_INDEX_BIT(4), .HIST_LEN(4), .TAG_BIT(8), .CTR_BIT(2),
                              .USE_GSHARE(0), .STAT_BIT(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    branch_predictor_gshare #(.NUM_INDEX_BIT(4), .HIST_LEN(4), .TAG_BIT(8), .CTR_BIT(2),
                              .USE_GSHARE(1), .STAT_BIT(4))
        dut_g (.clk(clk), .rst_n(rst_n), .bus(bus_g));

    assign bus_b.rd_pc_i = rd_pc;          assign bus_g.rd_pc_i = rd_pc;
    assign bus_b.rd_branch_i = rd_branch;  assign bus_g.rd_branch_i = rd_branch;
    assign bus_b.upd_valid_i = upd_valid;  assign bus_g.upd_valid_i = upd_valid;
    assign bus_b.upd_pc_i = upd_pc;        assign bus_g.upd_pc_i = upd_pc;
    assign bus_b.upd_ghr_i = upd_ghr;      assign bus_g.upd_ghr_i = upd_ghr;
    assign bus_b.upd_taken_i = upd_taken;  assign bus_g.upd_taken_i = upd_taken;
    assign bus_b.upd_pred_i = upd_pred;    assign bus_g.upd_pred_i = upd_pred;
    assign bus_b.upd_target_i = upd_target; assign bus_g.upd_target_i = upd_target;
    assign bus_b.stall_i = stall;          assign bus_g.stall_i = stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int f_bidx(logic [31:0] pc);
        return int'((pc >> 1) & 32'hF);
    endfunction

    function automatic int f_tag(logic [31:0] pc);
        return int'((pc >> 5) & 32'hFF);
    endfunction

    // Predicted taken-with-target for the bimodal (gs=0) or gshare (gs=1) model.
    function automatic bit m_hit(bit gs, logic [31:0] pc, bit br);
        int b = f_bidx(pc);
        int c = gs ? m_pht_g[b ^ m_ghr] : m_pht_b[b];
        return br && m_v[b] && (m_tag[b] == f_tag(pc)) && (c >= 2);
    endfunction

    function automatic int sat(int n, int bits);
        return (n > (1 << bits) - 1) ? (1 << bits) - 1 : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pht_b[i] = 1; m_pht_g[i] = 1; m_v[i] = 1'b0;
        end
        m_ghr = 0; m_nbr = 0; m_nmiss = 0;
    endtask

    task automatic model_update(logic [31:0] pc, int snap, bit taken, bit pred, logic [31:0] tgt);
        int b = f_bidx(pc);
        int pg = b ^ snap;
        if (taken) begin
            m_pht_b[b]  = (m_pht_b[b] < 3) ? m_pht_b[b] + 1 : 3;
            m_pht_g[pg] = (m_pht_g[pg] < 3) ? m_pht_g[pg] + 1 : 3;
            m_v[b] = 1'b1; m_tag[b] = f_tag(pc); m_tgt[b] = tgt;
        end else begin
            m_pht_b[b]  = (m_pht_b[b] > 0) ? m_pht_b[b] - 1 : 0;
            m_pht_g[pg] = (m_pht_g[pg] > 0) ? m_pht_g[pg] - 1 : 0;
        end
        m_ghr = (m_ghr * 2 + int'(taken)) % 16;
        m_nbr++;
        if (pred != taken) m_nmiss++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        upd_valid = 1'b0; stall = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One unstalled update presented for a single rising edge.
    task automatic do_update(logic [31:0] pc, int snap, bit taken, bit pred, logic [31:0] tgt);
        @(negedge clk);
        upd_pc = pc; upd_ghr = 4'(snap); upd_taken = taken; upd_pred = pred;
        upd_target = tgt; stall = 1'b0; upd_valid = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        model_update(pc, snap, taken, pred, tgt);
    endtask

    task automatic lookup(logic [31:0] pc);
        rd_pc = pc; rd_branch = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        lookup(32'h100);
        n_checks++; if (bus_b.rd_hit_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hit_b: got %0b expected 0", bus_b.rd_hit_o); end
        n_checks++; if (bus_g.rd_hit_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hit_g: got %0b expected 0", bus_g.rd_hit_o); end
        n_checks++; if (bus_g.rd_ghr_o !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_ghr: got %0h expected 0", bus_g.rd_ghr_o); end
        n_checks++; if (bus_b.stat_branch_o !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_stat_branch: got %0d expected 0", bus_b.stat_branch_o); end
        n_checks++; if (bus_b.stat_miss_o !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_stat_miss: got %0d expected 0", bus_b.stat_miss_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_update(32'h100, 0, 1'b1, 1'b0, 32'h80);
        do_update(32'h100, 0, 1'b1, 1'b0, 32'h80);
        lookup(32'h100);
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, 32'h100, 1'b1)) begin n_fail++; $display("[TB] FAIL basic_hit_b: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, 32'h100, 1'b1)); end
        n_checks++; if (bus_g.rd_hit_o !== m_hit(1, 32'h100, 1'b1)) begin n_fail++; $display("[TB] FAIL basic_hit_g: got %0b expected %0b", bus_g.rd_hit_o, m_hit(1, 32'h100, 1'b1)); end
        n_checks++; if (bus_b.rd_target_o !== 32'h80) begin n_fail++; $display("[TB] FAIL basic_target: got %0h expected 80", bus_b.rd_target_o); end
        n_checks++; if (bus_b.stat_branch_o !== 16'(m_nbr)) begin n_fail++; $display("[TB] FAIL basic_stat_branch: got %0d expected %0d", bus_b.stat_branch_o, m_nbr); end
        n_checks++; if (bus_b.stat_miss_o !== 16'(m_nmiss)) begin n_fail++; $display("[TB] FAIL basic_stat_miss: got %0d expected %0d", bus_b.stat_miss_o, m_nmiss); end
        n_checks++; if (bus_g.rd_ghr_o !== 4'(m_ghr)) begin n_fail++; $display("[TB] FAIL basic_ghr: got %0h expected %0h", bus_g.rd_ghr_o, m_ghr); end
    endtask

    task automatic test_alias();
        logic [31:0] alias_pc = 32'h100 + (32'h1 << 5);
        do_update(32'h100, m_ghr, 1'b1, 1'b1, 32'h80);
        lookup(alias_pc);
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, alias_pc, 1'b1)) begin n_fail++; $display("[TB] FAIL alias_miss: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, alias_pc, 1'b1)); end
        do_update(alias_pc, m_ghr, 1'b1, 1'b0, 32'h200);
        lookup(32'h100);
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, 32'h100, 1'b1)) begin n_fail++; $display("[TB] FAIL alias_evict: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, 32'h100, 1'b1)); end
        lookup(alias_pc);
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, alias_pc, 1'b1)) begin n_fail++; $display("[TB] FAIL alias_new_hit: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, alias_pc, 1'b1)); end
        n_checks++; if (bus_b.rd_target_o !== 32'h200) begin n_fail++; $display("[TB] FAIL alias_target: got %0h expected 200", bus_b.rd_target_o); end
    endtask

    // Alternating pattern: once warmed up, gshare predicts every outcome.
    task automatic test_gshare();
        int  base_miss = 0;
        bit  taken;
        bit  pred;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            taken = (i % 2 == 0);
            lookup(32'h40);
            pred = m_hit(1, 32'h40, 1'b1);
            if (i == 16) base_miss = m_nmiss;
            n_checks++; if (bus_g.rd_hit_o !== pred) begin n_fail++; $display("[TB] FAIL gshare_hit[%0d]: got %0b expected %0b", i, bus_g.rd_hit_o, pred); end
            n_checks++; if (bus_g.rd_ghr_o !== 4'(m_ghr)) begin n_fail++; $display("[TB] FAIL gshare_ghr[%0d]: got %0h expected %0h", i, bus_g.rd_ghr_o, m_ghr); end
            if (i >= 16) begin
                n_checks++; if (bus_g.rd_hit_o !== taken) begin n_fail++; $display("[TB] FAIL gshare_track[%0d]: got %0b expected %0b", i, bus_g.rd_hit_o, taken); end
            end
            do_update(32'h40, m_ghr, taken, pred, 32'h60);
        end
        n_checks++; if (bus_b.stat_miss_o !== 16'(base_miss)) begin n_fail++; $display("[TB] FAIL gshare_no_new_miss: got %0d expected %0d", bus_b.stat_miss_o, base_miss); end
    endtask

    task automatic test_saturation();
        bit taken;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            taken = 1'($urandom_range(0, 1));
            do_update(32'h300, m_ghr, taken, !taken, 32'h44);
        end
        n_checks++; if (bus_g.stat_miss_o !== 4'hF) begin n_fail++; $display("[TB] FAIL sat_miss_g: got %0h expected f", bus_g.stat_miss_o); end
        n_checks++; if (bus_g.stat_branch_o !== 4'(sat(m_nbr, 4))) begin n_fail++; $display("[TB] FAIL sat_branch_g: got %0h expected %0h", bus_g.stat_branch_o, sat(m_nbr, 4)); end
        n_checks++; if (bus_b.stat_miss_o !== 16'(m_nmiss)) begin n_fail++; $display("[TB] FAIL sat_miss_b: got %0d expected %0d", bus_b.stat_miss_o, m_nmiss); end
        for (int i = 0; i < 10; i++) do_update(32'h500, m_ghr, 1'b0, 1'b0, 32'h0);
        do_update(32'h500, m_ghr, 1'b1, 1'b0, 32'h88);
        lookup(32'h500);
        n_checks++; if (bus_b.rd_hit_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_ctr_one: got %0b expected 0", bus_b.rd_hit_o); end
        do_update(32'h500, m_ghr, 1'b1, 1'b0, 32'h88);
        lookup(32'h500);
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, 32'h500, 1'b1)) begin n_fail++; $display("[TB] FAIL sat_ctr_two: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, 32'h500, 1'b1)); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        upd_pc = 32'h700; upd_ghr = 4'(m_ghr); upd_taken = 1'b1; upd_pred = 1'b0;
        upd_target = 32'h99; stall = 1'b1; upd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        upd_valid = 1'b0; stall = 1'b0;
        lookup(32'h700);
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, 32'h700, 1'b1)) begin n_fail++; $display("[TB] FAIL stall_hit: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, 32'h700, 1'b1)); end
        n_checks++; if (bus_g.rd_ghr_o !== 4'(m_ghr)) begin n_fail++; $display("[TB] FAIL stall_ghr: got %0h expected %0h", bus_g.rd_ghr_o, m_ghr); end
        n_checks++; if (bus_b.stat_branch_o !== 16'(m_nbr)) begin n_fail++; $display("[TB] FAIL stall_stat_branch: got %0d expected %0d", bus_b.stat_branch_o, m_nbr); end
        n_checks++; if (bus_b.stat_miss_o !== 16'(m_nmiss)) begin n_fail++; $display("[TB] FAIL stall_stat_miss: got %0d expected %0d", bus_b.stat_miss_o, m_nmiss); end
    endtask

    // Lookup and update of the same entry in one cycle.
    task automatic test_back_to_back();
        bit          pre_hit;
        logic [31:0] pre_tgt;
        int          b = f_bidx(32'h700);
        do_update(32'h700, m_ghr, 1'b1, 1'b0, 32'h1234);
        pre_hit = m_hit(0, 32'h700, 1'b1);
        pre_tgt = m_tgt[b];
        @(negedge clk);
        rd_pc = 32'h700; rd_branch = 1'b1;
        upd_pc = 32'h700; upd_ghr = 4'(m_ghr); upd_taken = 1'b1; upd_pred = 1'b0;
        upd_target = 32'h5678; stall = 1'b0; upd_valid = 1'b1;
        #1;
        n_checks++; if (bus_b.rd_hit_o !== pre_hit) begin n_fail++; $display("[TB] FAIL same_cycle_hit: got %0b expected %0b", bus_b.rd_hit_o, pre_hit); end
        n_checks++; if (bus_b.rd_target_o !== pre_tgt) begin n_fail++; $display("[TB] FAIL same_cycle_target: got %0h expected %0h", bus_b.rd_target_o, pre_tgt); end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        model_update(32'h700, int'(upd_ghr), 1'b1, 1'b0, 32'h5678);
        n_checks++; if (bus_b.rd_target_o !== 32'h5678) begin n_fail++; $display("[TB] FAIL next_cycle_target: got %0h expected 5678", bus_b.rd_target_o); end
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, 32'h700, 1'b1)) begin n_fail++; $display("[TB] FAIL next_cycle_hit: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, 32'h700, 1'b1)); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8] = '{32'h100, 32'h120, 32'h140, 32'h40, 32'h2a, 32'h52a, 32'h3e, 32'h1000};
        int b;
        int snap;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rd_pc = pool[$urandom_range(0, 7)];
            rd_branch = 1'($urandom_range(0, 3) != 0);
            upd_pc = pool[$urandom_range(0, 7)];
            snap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : m_ghr;
            upd_ghr = 4'(snap);
            upd_taken = 1'($urandom_range(0, 1));
            upd_pred = ($urandom_range(0, 1) == 0) ? m_hit(1, upd_pc, 1'b1) : 1'($urandom_range(0, 1));
            upd_target = $urandom & 32'hFFFF_FFFE;
            stall = ($urandom_range(0, 4) == 0);
            upd_valid = 1'($urandom_range(0, 3) != 0);
            #1;
            b = f_bidx(rd_pc);
            n_checks++; if (bus_b.rd_hit_o !== m_hit(0, rd_pc, rd_branch)) begin n_fail++; $display("[TB] FAIL rand_hit_b[%0d]: got %0b expected %0b", i, bus_b.rd_hit_o, m_hit(0, rd_pc, rd_branch)); end
            n_checks++; if (bus_g.rd_hit_o !== m_hit(1, rd_pc, rd_branch)) begin n_fail++; $display("[TB] FAIL rand_hit_g[%0d]: got %0b expected %0b", i, bus_g.rd_hit_o, m_hit(1, rd_pc, rd_branch)); end
            n_checks++; if (bus_g.rd_ghr_o !== 4'(m_ghr)) begin n_fail++; $display("[TB] FAIL rand_ghr[%0d]: got %0h expected %0h", i, bus_g.rd_ghr_o, m_ghr); end
            n_checks++; if (bus_g.stat_miss_o !== 4'(sat(m_nmiss, 4))) begin n_fail++; $display("[TB] FAIL rand_miss_g[%0d]: got %0d expected %0d", i, bus_g.stat_miss_o, sat(m_nmiss, 4)); end
            n_checks++; if (bus_b.stat_branch_o !== 16'(m_nbr)) begin n_fail++; $display("[TB] FAIL rand_branch_b[%0d]: got %0d expected %0d", i, bus_b.stat_branch_o, m_nbr); end
            if (m_v[b]) begin
                n_checks++; if (bus_g.rd_target_o !== m_tgt[b]) begin n_fail++; $display("[TB] FAIL rand_target[%0d]: got %0h expected %0h", i, bus_g.rd_target_o, m_tgt[b]); end
            end
            @(posedge clk);
            #1;
            if (upd_valid && !stall) model_update(upd_pc, snap, upd_taken, upd_pred, upd_target);
            upd_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        do_update(32'h100, m_ghr, 1'b1, 1'b0, 32'h80);
        do_update(32'h100, m_ghr, 1'b1, 1'b0, 32'h80);
        lookup(32'h100);
        n_checks++; if (bus_b.rd_hit_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_hit: got %0b expected 1", bus_b.rd_hit_o); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (bus_b.rd_hit_o !== 1'b0) begin n_fail++; $display("[TB] FAIL async_hit: got %0b expected 0", bus_b.rd_hit_o); end
        n_checks++; if (bus_g.rd_ghr_o !== 4'h0) begin n_fail++; $display("[TB] FAIL async_ghr: got %0h expected 0", bus_g.rd_ghr_o); end
        n_checks++; if (bus_b.stat_branch_o !== 16'h0) begin n_fail++; $display("[TB] FAIL async_branch: got %0d expected 0", bus_b.stat_branch_o); end
        n_checks++; if (bus_g.stat_miss_o !== 4'h0) begin n_fail++; $display("[TB] FAIL async_miss: got %0d expected 0", bus_g.stat_miss_o); end
        upd_pc = 32'h100; upd_ghr = 4'h0; upd_taken = 1'b1; upd_pred = 1'b0;
        upd_target = 32'h80; stall = 1'b0; upd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus_b.stat_branch_o !== 16'(m_nbr)) begin n_fail++; $display("[TB] FAIL discard_branch: got %0d expected %0d", bus_b.stat_branch_o, m_nbr); end
        n_checks++; if (bus_b.rd_hit_o !== m_hit(0, 32'h100, 1'b1)) begin n_fail++; $display("[TB] FAIL discard_hit: got %0b expected %0b", bus_b.rd_hit_o, m_hit(0, 32'h100, 1'b1)); end
        n_checks++; if (bus_g.rd_ghr_o !== 4'(m_ghr)) begin n_fail++; $display("[TB] FAIL discard_ghr: got %0h expected %0h", bus_g.rd_ghr_o, m_ghr); end
    endtask

    initial begin
        rst_n = 1'b0; rd_pc = '0; rd_branch = 1'b0; upd_valid = 1'b0; upd_pc = '0;
        upd_ghr = '0; upd_taken = 1'b0; upd_pred = 1'b0; upd_target = '0; stall = 1'b0;
        $display("[TB] starting branch_predictor_gshare bench");
        test_reset();
        test_basic();
        test_alias();
        test_gshare();
        test_saturation();
        test_stall();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the pipeline's 16-entry direction/target predictor.
- Adds three things:
  - a gshare direction table (global history XOR PC), with a bimodal fallback mode;
  - a tagged BTB, instead of an untagged one;
  - saturating performance counters.
- Lookup is combinational in IF. Update is synchronous from EX resolution.
- Halfword-aligned PCs are supported, for compressed instructions.

Parameters:
- NUM_INDEX_BIT, 4: log2 of PHT and BTB entries; index taken from PC[NUM_INDEX_BIT:1].
- HIST_LEN, 4: global history bits; legal range 1..NUM_INDEX_BIT.
- TAG_BIT, 8: BTB tag width, taken from PC[NUM_INDEX_BIT+TAG_BIT:NUM_INDEX_BIT+1].
- CTR_BIT, 2: PHT saturating-counter width; legal range 2..4.
- USE_GSHARE, 1: 1 = index XOR zero-extended history; 0 = bimodal (history ignored for indexing, still tracked).
- STAT_BIT, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_pc_i  in  32  IF fetch PC
- rd_branch_i  in  1  IF instruction is a conditional branch
- rd_hit_o  out  1  predict taken with a valid target
- rd_target_o  out  32  predicted target
- rd_ghr_o  out  HIST_LEN  history snapshot; pipeline carries it to EX
- upd_valid_i  in  1  EX resolved a conditional branch this cycle
- upd_pc_i  in  32  PC of the resolved branch
- upd_ghr_i  in  HIST_LEN  snapshot that was carried with the branch
- upd_taken_i  in  1  actual outcome
- upd_pred_i  in  1  rd_hit_o value that was carried with the branch
- upd_target_i  in  32  actual taken target
- stall_i  in  1  pipeline stall; blocks all state updates
- stat_branch_o  out  STAT_BIT  resolved-branch count
- stat_miss_o  out  STAT_BIT  misprediction count

Behaviour:
- Reset (async, rst_n=0):
  - all PHT counters = weakly not-taken (2^(CTR_BIT-1))-1, i.e. 01 for CTR_BIT=2;
  - all BTB valid bits = 0; tags and targets don't-care;
  - GHR = 0; both stat counters = 0.
  - Outputs during reset: rd_hit_o=0, rd_ghr_o=0, stats 0.
  - Reset asserted mid-update discards that update.
- Lookup (combinational, zero latency):
  - bidx = rd_pc_i[NUM_INDEX_BIT:1].
  - pidx = bidx ^ {0, GHR} when USE_GSHARE=1, else bidx.
  - hit condition: rd_branch_i & btb_valid[bidx] & (btb_tag[bidx] == rd_pc tag field) & pht[pidx][CTR_BIT-1].
  - rd_target_o = btb_target[bidx], regardless of hit.
  - rd_ghr_o = GHR.
- Update fires on a rising edge when upd_valid_i=1 and stall_i=0. It uses uidx = upd_pc_i[NUM_INDEX_BIT:1] and upd_pidx built from upd_ghr_i in the same way as pidx.
  - PHT: if taken, increment upd_pidx entry saturating at 2^CTR_BIT-1; if not taken, decrement saturating at 0.
  - BTB: on taken, write valid=1, tag, and target=upd_target_i to uidx. A tag mismatch replaces the entry (direct-mapped). On not-taken, the BTB is unchanged.
  - GHR <= {GHR[HIST_LEN-2:0], upd_taken_i}. For HIST_LEN=1, GHR <= upd_taken_i.
  - stat_branch_o +1, saturating at all-ones.
  - stat_miss_o +1 when upd_pred_i != upd_taken_i, saturating at all-ones.
- stall_i=1 with upd_valid_i=1: no state changes. The pipeline re-presents the update in a later cycle.
- Same-cycle lookup and update of the same entry: the lookup sees pre-update values; the new value is visible the following cycle.
- Invalid parameter combinations (HIST_LEN>NUM_INDEX_BIT, CTR_BIT outside 2..4) are rejected at elaboration.

Test Plan:
1. Reset, then rd_pc_i=0x100 with rd_branch_i=1 -> rd_hit_o=0, rd_ghr_o=0, stats 0.
2. Two taken updates, pc=0x100, target=0x80, ghr=0, USE_GSHARE=0 -> lookup of 0x100 gives rd_hit_o=1, rd_target_o=0x80; stat_branch_o=2, and stat_miss_o=2 if upd_pred_i=0 both times.
3. Aliasing: taken update at pc=0x100, then lookup pc=0x100+(1<<(NUM_INDEX_BIT+1)) -> tag mismatch, rd_hit_o=0. A taken update at that alias overwrites the entry, after which 0x100 misses.
4. Gshare: outcome pattern T,N,T,N on pc=0x40 with snapshots fed back correctly -> after warm-up, GHR alternates 0101/1010 and prediction tracks the pattern with 0 new misses over 8 further branches.
5. Saturation: STAT_BIT=4, 20 mispredicted updates -> stat_miss_o stays 0xF. 10 not-taken updates on one entry -> counter at 0; one taken update -> counter=1, hit still 0.
6. stall_i=1 with upd_valid_i=1 for 3 cycles -> no change to GHR, PHT or stats. Assert rst_n=0 asynchronously mid-cycle -> outputs return to reset values immediately.
